// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg
// Shared types for the Z80 bus responder:
//   LOG_W        - width of one write-log entry
//   log_entry_t  - {is_io, addr[15:0], data[7:0]} as seen on log_data
//   wait_state_t - wait-state FSM encoding
//   make_entry   - packs a bus write into a log entry
package z80_bus_pkg;

    localparam int LOG_W = 25;

    typedef struct packed {
        logic        is_io;
        logic [15:0] addr;
        logic [7:0]  data;
    } log_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } wait_state_t;

    function automatic log_entry_t make_entry(input logic        is_io,
                                              input logic [15:0] addr,
                                              input logic [7:0]  data);
        log_entry_t e;
        e.is_io = is_io;
        e.addr  = addr;
        e.data  = data;
        return e;
    endfunction

endpackage

// File: rtl/z80_wrlog_fifo.sv
// z80_wrlog_fifo
// Single-clock FIFO holding bus write-log entries.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   push, push_data     - enqueue request and entry
//   pop_valid/pop_ready - head-of-queue handshake; pop on valid & ready
//   pop_data            - head entry
//   full                - all DEPTH slots occupied
//   ovf                 - sticky: a push was dropped because the FIFO was full
module z80_wrlog_fifo
    import z80_bus_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [LOG_W-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [LOG_W-1:0] pop_data,
    output logic             full,
    output logic             ovf
);

    localparam int PW = $clog2(DEPTH);

    logic [LOG_W-1:0] store [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             pop;
    logic             do_push;

    assign pop_valid = (wptr != rptr);
    assign full      = (wptr[PW-1:0] == rptr[PW-1:0]) && (wptr[PW] != rptr[PW]);
    assign pop       = pop_valid && pop_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push   = push && (!full || pop);
    assign pop_data  = store[rptr[PW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder
// Memory / I/O target for a Z80 CPU bus with programmable wait states and an
// optional write log.
// Ports:
//   clk, reset                  - CPU clock, asynchronous active-high reset
//   m1_n, mreq_n, iorq_n,
//   rd_n, wr_n, rfsh_n          - CPU bus strobes (active-low)
//   A, dout                     - CPU address and write data
//   di                          - read data to CPU, registered on falling clk
//   wait_n                      - wait request to CPU (active-low)
//   log_valid/log_ready/log_data- write-log stream {is_io, A, data}
//   log_ovf                     - sticky write-log overflow
// Build option: define Z80_BUS_WRLOG_EN to include the write log; otherwise
// the log outputs are tied low and log_ready is ignored.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int MEM_AW    = 16,
    parameter int IO_AW     = 8,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 1,
    parameter int LOG_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m1_n,
    input  logic             mreq_n,
    input  logic             iorq_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic             rfsh_n,
    input  logic [15:0]      A,
    input  logic [7:0]       dout,
    output logic [7:0]       di,
    output logic             wait_n,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [LOG_W-1:0] log_data,
    output logic             log_ovf
);

    // Contents are never cleared; the environment preloads them.
    logic [7:0] mem [2**MEM_AW];
    logic [7:0] io  [2**IO_AW];

    wait_state_t state;
    logic [7:0]  wait_cnt;
    logic        armed;
    logic        access_req;
    logic [7:0]  load_cnt;

    assign access_req = rfsh_n && (!mreq_n || !iorq_n) && (!rd_n || !wr_n);
    assign load_cnt   = !mreq_n ? 8'(MEM_WAIT) : 8'(IO_WAIT);

    // Falling edge: read data and storage writes. Refresh cycles are ignored,
    // and an interrupt acknowledge (iorq_n with m1_n) returns an idle bus.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            di <= 8'h00;
        end else if (rfsh_n) begin
            if (!mreq_n)                di <= mem[A[MEM_AW-1:0]];
            else if (!iorq_n && m1_n)   di <= io[A[IO_AW-1:0]];
            else if (!iorq_n && !m1_n)  di <= 8'hFF;
        end
    end

    always_ff @(negedge clk) begin
        if (!wr_n && rfsh_n) begin
            if (!mreq_n)              mem[A[MEM_AW-1:0]] <= dout;
            else if (!iorq_n && m1_n) io[A[IO_AW-1:0]]   <= dout;
        end
    end

    // Rising edge: wait-state FSM. 'armed' blocks a strobe that was already
    // low when reset released from being taken as a fresh access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_n   <= 1'b1;
            wait_cnt <= 8'd0;
            armed    <= 1'b0;
        end else begin
            if (mreq_n && iorq_n) armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (armed && access_req) begin
                        if (load_cnt == 8'd0) begin
                            state <= ST_HOLD;
                        end else begin
                            state    <= ST_WAIT;
                            wait_n   <= 1'b0;
                            wait_cnt <= load_cnt;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 8'd1) begin
                        state  <= ST_HOLD;
                        wait_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (mreq_n && iorq_n) state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    wait_n <= 1'b1;
                end
            endcase
        end
    end

`ifdef Z80_BUS_WRLOG_EN
    logic       wr_cyc;
    logic       wr_seen;
    logic       push_pend;
    log_entry_t push_entry;
    logic       log_full_unused;

    assign wr_cyc = rfsh_n && !wr_n && (!mreq_n || !iorq_n);

    // The entry is captured at the first falling edge of a write cycle and
    // handed to the FIFO on the following rising edge. wr_seen resets high
    // so a write still in progress across reset is not logged.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            wr_seen   <= 1'b1;
            push_pend <= 1'b0;
        end else begin
            push_pend <= wr_cyc && !wr_seen;
            wr_seen   <= wr_cyc;
        end
    end

    always_ff @(negedge clk) begin
        if (wr_cyc && !wr_seen) push_entry <= make_entry(mreq_n, A, dout);
    end

    z80_wrlog_fifo #(
        .DEPTH(LOG_DEPTH)
    ) u_wrlog (
        .clk       (clk),
        .reset     (reset),
        .push      (push_pend),
        .push_data (push_entry),
        .pop_valid (log_valid),
        .pop_ready (log_ready),
        .pop_data  (log_data),
        .full      (log_full_unused),
        .ovf       (log_ovf)
    );
`else
    logic unused_log_ready;
    assign unused_log_ready = log_ready;
    assign log_valid = 1'b0;
    assign log_data  = '0;
    assign log_ovf   = 1'b0;
`endif

endmodule
